voice_synth: RTL and testbench

VOICE_SYNTH -- requirements
Module: voice_synth

---
 rtl/voice_synth_if.sv | 15 +
 rtl/voice_synth.sv | 156 +++++++++++++++
 tb/tb_voice_synth.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/voice_synth_if.sv
// Configuration handshake bus for voice_synth: valid/ready with address and data.
interface voice_synth_if #(
  parameter int unsigned NVOICES = 3,
  parameter int unsigned PW      = 32
);
  localparam int unsigned AW = $clog2(NVOICES + 1);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [PW-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/voice_synth.sv
// Multi-voice tone generator: per-voice phase counters, shared waveform shaper,
// enable-masked mix with gain shift and saturation to the output width.
module voice_synth #(
  parameter int unsigned NVOICES = 3,
  parameter int unsigned PW      = 32,
  parameter int unsigned OW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  voice_synth_if.slave  cfg,
  output logic [OW-1:0] wave
);
  localparam int unsigned AW = $clog2(NVOICES + 1);
  localparam int unsigned SW = 4 + $clog2(NVOICES) + 3;
  localparam int unsigned CW = ((SW > OW) ? SW : OW) + 1;

  localparam logic [3:0] SINE [32] = '{
    4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15,
    4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd12, 4'd10, 4'd9,
    4'd8, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0,
    4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};

  typedef enum logic {IDLE, APPLY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PW-1:0] data_q, data_d;
  logic          ready_d;

  logic [1:0]         wf_q;
  logic [1:0]         gain_q;
  logic [NVOICES-1:0] en_q;

  logic [PW-1:0] cnt_q     [NVOICES];
  logic [PW-1:0] active_q  [NVOICES];
  logic [PW-1:0] pend_q    [NVOICES];
  logic [4:0]    ph_q      [NVOICES];
  logic [PW-1:0] step_last [NVOICES];
  logic [3:0]    lvl       [NVOICES];

  logic          apply_period, apply_ctrl, resync;
  logic [SW-1:0] sum, shifted;
  logic [OW-1:0] sat;

  function automatic logic [3:0] level_f(input logic [1:0] wf, input logic [4:0] p);
    case (wf)
      2'd0:    level_f = {4{p[4]}};
      2'd1:    level_f = p[4:1];
      2'd2:    level_f = p[4] ? ~p[3:0] : p[3:0];
      default: level_f = SINE[p];
    endcase
  endfunction

  // Config FSM state and captured write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      cfg.cfg_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cfg.cfg_ready <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_valid && cfg.cfg_ready) begin
          addr_d  = cfg.cfg_addr;
          data_d  = cfg.cfg_data;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Addresses above the control register fall through both decodes and are dropped
  assign apply_period = (state_q == APPLY) && (addr_q < AW'(NVOICES));
  assign apply_ctrl   = (state_q == APPLY) && (addr_q == AW'(NVOICES));
  assign resync       = apply_ctrl && data_q[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf_q   <= '0;
      gain_q <= '0;
      en_q   <= '0;
    end else if (apply_ctrl) begin
      wf_q   <= data_q[1:0];
      gain_q <= data_q[3:2];
      en_q   <= data_q[5 +: NVOICES];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NVOICES); i++) begin
      step_last[i] = (active_q[i] >> 5) - PW'(1);
      lvl[i]       = (active_q[i] < PW'(32)) ? 4'd0 : level_f(wf_q, ph_q[i]);
    end
  end

  // Voice counters; a pending period is taken only at phase wrap or while silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        cnt_q[i]    <= '0;
        ph_q[i]     <= '0;
        active_q[i] <= '0;
        pend_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        if (apply_period && (addr_q == AW'(i))) pend_q[i] <= data_q;
        if (active_q[i] < PW'(32)) begin
          cnt_q[i]    <= '0;
          ph_q[i]     <= '0;
          active_q[i] <= pend_q[i];
        end else if (cnt_q[i] == step_last[i]) begin
          cnt_q[i] <= '0;
          ph_q[i]  <= ph_q[i] + 5'd1;
          if (ph_q[i] == 5'd31) active_q[i] <= pend_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + PW'(1);
        end
        if (resync) begin
          cnt_q[i] <= '0;
          ph_q[i]  <= '0;
        end
      end
    end
  end

  // Mix, gain and saturate
  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(NVOICES); i++) begin
      if (en_q[i]) sum = sum + SW'(lvl[i]);
    end
    shifted = sum << gain_q;
    if (CW'(shifted) > CW'({OW{1'b1}})) sat = '1;
    else                                sat = OW'(shifted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wave <= '0;
    else        wave <= sat;
  end
endmodule

// File: tb/tb_voice_synth.sv
// Self-checking bench for voice_synth: vector table of mix configurations plus
// directed sequences for period reload, bad address and reset during apply.
module tb_voice_synth;
  localparam int unsigned NV = 5;
  localparam int unsigned PW = 32;
  localparam int unsigned OW = 8;
  localparam int unsigned AW = $clog2(NV + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [OW-1:0] wave;

  voice_synth_if #(.NVOICES(NV), .PW(PW)) bus ();

  voice_synth #(.NVOICES(NV), .PW(PW), .OW(OW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cfg  (bus),
    .wave (wave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wf;
    int gain;
    int en;
    int peak;
  } vec_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_q[$];
  string tag;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int lvl(input int wf, input int ph);
    case (wf)
      0:       return (ph < 16) ? 0 : 15;
      1:       return ph / 2;
      2:       return (ph < 16) ? ph : 31 - ph;
      default: return int'($floor(7.5 + 7.5 * $sin(2.0 * 3.14159265358979 * ph / 32.0) + 0.5));
    endcase
  endfunction

  function automatic int popc(input int v);
    int c = 0;
    for (int b = 0; b < int'(NV); b++) c += (v >> b) & 1;
    return c;
  endfunction

  function automatic int expw(input int wf, input int gain, input int en, input int ph);
    int e = (popc(en) * lvl(wf, ph)) << gain;
    return (e > 255) ? 255 : e;
  endfunction

  function automatic logic [PW-1:0] ctrl(input int wf, input int gain, input int en, input bit rs);
    logic [PW-1:0] d = '0;
    d[1:0] = 2'(wf);
    d[3:2] = 2'(gain);
    d[4]   = rs;
    d[9:5] = 5'(en);
    return d;
  endfunction

  task automatic cfg_write(input int a, input logic [PW-1:0] d);
    int n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check("cfg_ready_wait", int'(bus.cfg_ready), 1);
    bus.cfg_addr  = AW'(a);
    bus.cfg_data  = d;
    bus.cfg_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    check("cfg_ready_in_apply", int'(bus.cfg_ready), 0);
  endtask

  task automatic sb_step(output int obs);
    @(posedge clk); #1;
    obs = int'(wave);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %0d", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   obs, peak;

    vecs[0] = '{2, 0, 5'b00111, 45};
    vecs[1] = '{2, 0, 5'b11111, 75};
    vecs[2] = '{1, 1, 5'b00011, 60};
    vecs[3] = '{0, 3, 5'b00111, 255};
    vecs[4] = '{3, 2, 5'b00101, 120};
    vecs[5] = '{3, 0, 5'b00000, 0};
    vecs[6] = '{0, 1, 5'b11111, 150};

    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    rst_n         = 1'b0;

    // Reset state and ready release timing
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", int'(wave), 0);
    check("rst_ready", int'(bus.cfg_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", int'(bus.cfg_ready), 0);
    @(posedge clk); #1;
    check("ready_first_edge", int'(bus.cfg_ready), 1);

    for (int i = 0; i < int'(NV); i++) cfg_write(i, PW'(32));
    repeat (2) @(posedge clk);
    #1;

    // Vector table: all periods 32, resync aligns phases, one sample per phase step
    for (int v = 0; v < 7; v++) begin
      cfg_write(NV, ctrl(vecs[v].wf, vecs[v].gain, vecs[v].en, 1'b1));
      @(posedge clk); #1;
      tag = $sformatf("vec%0d_wave", v);
      for (int k = 0; k < 64; k++) exp_q.push_back(expw(vecs[v].wf, vecs[v].gain, vecs[v].en, k % 32));
      peak = 0;
      for (int k = 0; k < 64; k++) begin
        sb_step(obs);
        if (obs > peak) peak = obs;
      end
      check($sformatf("vec%0d_peak", v), peak, vecs[v].peak);
    end

    // Out-of-range addresses: ready drops one cycle, tone undisturbed
    cfg_write(NV, ctrl(2, 0, 5'b11111, 1'b1));
    @(posedge clk); #1;
    tag = "badaddr_wave";
    for (int k = 0; k < 64; k++) exp_q.push_back(expw(2, 0, 5'b11111, k % 32));
    fork
      begin
        for (int k = 0; k < 64; k++) sb_step(obs);
      end
      begin
        repeat (9) @(posedge clk);
        #1;
        cfg_write(NV + 1, '0);
        @(posedge clk); #1;
        check("badaddr6_ready_back", int'(bus.cfg_ready), 1);
        cfg_write(7, ctrl(0, 3, 5'b11111, 1'b1));
        @(posedge clk); #1;
        check("badaddr7_ready_back", int'(bus.cfg_ready), 1);
      end
    join

    // Voice0 period 64 square: 32 clks low, 32 clks high
    cfg_write(0, PW'(64));
    repeat (40) @(posedge clk);
    #1;
    cfg_write(NV, ctrl(0, 0, 5'b00001, 1'b1));
    @(posedge clk); #1;
    tag = "sq64_wave";
    for (int j = 1; j <= 128; j++) exp_q.push_back(((((j - 1) / 2) % 32) < 16) ? 0 : 15);
    for (int j = 1; j <= 128; j++) sb_step(obs);

    // Period 128 written near ph=10 takes effect only after the wrap
    cfg_write(NV, ctrl(1, 0, 5'b00001, 1'b1));
    @(posedge clk); #1;
    tag = "reload_wave";
    for (int j = 1; j <= 192; j++)
      exp_q.push_back((j <= 64) ? (((j - 1) / 2) >> 1) : (((j - 65) / 4) >> 1));
    fork
      begin
        for (int j = 1; j <= 192; j++) sb_step(obs);
      end
      begin
        repeat (19) @(posedge clk);
        #1;
        cfg_write(0, PW'(128));
      end
    join

    // Reset asserted while a write is in APPLY
    cfg_write(NV, ctrl(3, 0, 5'b11111, 1'b1));
    @(posedge clk); #1;
    bus.cfg_addr  = AW'(NV);
    bus.cfg_data  = ctrl(3, 0, 5'b11111, 1'b0);
    bus.cfg_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    check("pre_reset_wave", int'(wave), expw(3, 0, 5'b11111, 0));
    check("pre_reset_ready", int'(bus.cfg_ready), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_wave", int'(wave), 0);
    check("async_rst_ready", int'(bus.cfg_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rerelease_ready_low", int'(bus.cfg_ready), 0);
    @(posedge clk); #1;
    check("rerelease_ready_high", int'(bus.cfg_ready), 1);
    cfg_write(NV, ctrl(3, 0, 5'b11111, 1'b0));
    @(posedge clk); #1;
    tag = "silent_wave";
    for (int k = 0; k < 40; k++) exp_q.push_back(0);
    for (int k = 0; k < 40; k++) sb_step(obs);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
